// File: rtl/uart_block_framer.sv
// uart_block_framer
//   Collects NBYTES bytes from the UART receiver into one plaintext block,
//   hands the block to a block cipher core, waits for the ciphertext and then
//   sends it back out one byte at a time through the UART transmitter.
//   A partial frame is dropped if the gap between bytes grows too long.
//
// Parameters
//   NBYTES          bytes per block (block width is 8*NBYTES)
//   TIMEOUT_CYCLES  clk cycles allowed between bytes of a partial frame, 0 = off
//   MSB_FIRST       1: first byte on the wire is the top byte of the block
//                   0: first byte on the wire is bits [7:0]
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   rx_valid, rx_data      received byte strobe and data
//   tx_start, tx_data      transmit request pulse and byte (held until tx_done)
//   tx_done                transmitter finished the current byte
//   aes_start, pt_to_aes   cipher start pulse and plaintext block
//   aes_ready, ct_from_aes cipher result valid (level) and ciphertext block
//   busy                   high whenever a frame is past the receive phase
//   overrun                pulse: a byte arrived while busy and was dropped
//   frame_err              pulse: partial frame dropped by the inter-byte timeout
//   frame_done             pulse: last ciphertext byte has been sent
module uart_block_framer #(
    parameter int NBYTES         = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_done,
    output logic                aes_start,
    input  logic                aes_ready,
    output logic [8*NBYTES-1:0] pt_to_aes,
    input  logic [8*NBYTES-1:0] ct_from_aes,
    output logic                busy,
    output logic                overrun,
    output logic                frame_err,
    output logic                frame_done
);

    localparam int BW = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    // lane of ct_from_aes that goes out first
    localparam int FIRST_LANE = MSB_FIRST ? NBYTES - 1 : 0;

    typedef enum logic [2:0] {
        RECV,
        START,
        WAIT_AES,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] k_reg;
    logic [TW-1:0] tmo_reg;
    logic [BW-1:0] pt_reg;
    logic [BW-1:0] ct_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_start_reg;
    logic          aes_start_reg;
    logic          overrun_reg;
    logic          frame_err_reg;
    logic          frame_done_reg;

    // Captured ciphertext rearranged into wire order: byte k of ct_seq is
    // the k-th byte to transmit, whatever MSB_FIRST says.
    logic [BW-1:0] ct_seq;
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_wire_order
            localparam int LANE = MSB_FIRST ? NBYTES - 1 - gi : gi;
            assign ct_seq[8*gi +: 8] = ct_reg[8*LANE +: 8];
        end
    endgenerate

    // block lane that receives the byte currently being accepted
    logic [CW-1:0] pt_slot;
    assign pt_slot = MSB_FIRST ? (LAST_IDX - cnt_reg) : cnt_reg;

    logic [CW-1:0] k_next;
    assign k_next = k_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RECV;
            cnt_reg        <= '0;
            k_reg          <= '0;
            tmo_reg        <= '0;
            pt_reg         <= '0;
            ct_reg         <= '0;
            tx_data_reg    <= '0;
            tx_start_reg   <= 1'b0;
            aes_start_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            // pulse outputs default low; each is raised on the edge that
            // enters the state it belongs to, so it is high during that state
            tx_start_reg   <= 1'b0;
            aes_start_reg  <= 1'b0;
            frame_err_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= rx_valid && (state_reg != RECV);

            case (state_reg)
                RECV: begin
                    if (rx_valid) begin
                        pt_reg[8*pt_slot +: 8] <= rx_data;
                        tmo_reg <= '0;
                        if (cnt_reg == LAST_IDX) begin
                            cnt_reg       <= '0;
                            aes_start_reg <= 1'b1;
                            state_reg     <= START;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else if (TMO_EN && (cnt_reg != '0)) begin
                        if (tmo_reg == TMO_LAST) begin
                            cnt_reg       <= '0;
                            tmo_reg       <= '0;
                            frame_err_reg <= 1'b1;
                        end else begin
                            tmo_reg <= tmo_reg + 1'b1;
                        end
                    end else begin
                        tmo_reg <= '0;
                    end
                end
                START: begin
                    // aes_ready is deliberately not sampled here: it may
                    // still be left over from the previous block
                    state_reg <= WAIT_AES;
                end
                WAIT_AES: begin
                    if (aes_ready) begin
                        ct_reg       <= ct_from_aes;
                        tx_data_reg  <= ct_from_aes[8*FIRST_LANE +: 8];
                        tx_start_reg <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    state_reg <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (k_reg == LAST_IDX) begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= DONE;
                        end else begin
                            k_reg        <= k_next;
                            tx_data_reg  <= ct_seq[8*k_next +: 8];
                            tx_start_reg <= 1'b1;
                            state_reg    <= SEND;
                        end
                    end
                end
                DONE: begin
                    k_reg     <= '0;
                    state_reg <= RECV;
                end
                default: begin
                    state_reg <= RECV;
                end
            endcase
        end
    end

    assign pt_to_aes  = pt_reg;
    assign tx_data    = tx_data_reg;
    assign tx_start   = tx_start_reg;
    assign aes_start  = aes_start_reg;
    assign overrun    = overrun_reg;
    assign frame_err  = frame_err_reg;
    assign frame_done = frame_done_reg;
    assign busy       = (state_reg != RECV);

endmodule

// File: tb/tb_uart_block_framer.sv
// tb_uart_block_framer
//   Drives three framer instances: a 16-byte MSB-first block with a short
//   timeout, a 4-byte LSB-first block with the timeout disabled, and a
//   1-byte block. Expected blocks and byte streams come from simple
//   shift arithmetic on the bytes sent and the ciphertext supplied.
`timescale 1ns/1ps
module tb_uart_block_framer;

    localparam int TMO_A = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // instance A: 16 bytes, MSB first, timeout 50
    logic         rx_valid, tx_start, tx_done, aes_start, aes_ready;
    logic         busy, overrun, frame_err, frame_done;
    logic [7:0]   rx_data, tx_data;
    logic [127:0] pt_to_aes, ct_from_aes;

    uart_block_framer #(.NBYTES(16), .TIMEOUT_CYCLES(TMO_A), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .aes_start(aes_start), .aes_ready(aes_ready), .pt_to_aes(pt_to_aes),
        .ct_from_aes(ct_from_aes), .busy(busy), .overrun(overrun),
        .frame_err(frame_err), .frame_done(frame_done)
    );

    // instance B: 4 bytes, LSB first, timeout disabled
    logic        b_rx_valid, b_tx_start, b_tx_done, b_aes_start, b_aes_ready;
    logic        b_busy, b_overrun, b_frame_err, b_frame_done;
    logic [7:0]  b_rx_data, b_tx_data;
    logic [31:0] b_pt, b_ct;

    uart_block_framer #(.NBYTES(4), .TIMEOUT_CYCLES(0), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
        .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_done(b_tx_done),
        .aes_start(b_aes_start), .aes_ready(b_aes_ready), .pt_to_aes(b_pt),
        .ct_from_aes(b_ct), .busy(b_busy), .overrun(b_overrun),
        .frame_err(b_frame_err), .frame_done(b_frame_done)
    );

    // instance C: single-byte block
    logic       c_rx_valid, c_tx_start, c_tx_done, c_aes_start, c_aes_ready;
    logic       c_busy, c_overrun, c_frame_err, c_frame_done;
    logic [7:0] c_rx_data, c_tx_data, c_pt, c_ct;

    uart_block_framer #(.NBYTES(1), .TIMEOUT_CYCLES(3), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .reset(reset), .rx_valid(c_rx_valid), .rx_data(c_rx_data),
        .tx_start(c_tx_start), .tx_data(c_tx_data), .tx_done(c_tx_done),
        .aes_start(c_aes_start), .aes_ready(c_aes_ready), .pt_to_aes(c_pt),
        .ct_from_aes(c_ct), .busy(c_busy), .overrun(c_overrun),
        .frame_err(c_frame_err), .frame_done(c_frame_done)
    );

    int checks   = 0;
    int failures = 0;

    // pulse counters, sampled mid-cycle
    int n_tx_start = 0, n_aes_start = 0, n_overrun = 0;
    int n_frame_err = 0, n_frame_done = 0, n_b_frame_err = 0;
    always @(negedge clk) begin
        if (tx_start)    n_tx_start    <= n_tx_start + 1;
        if (aes_start)   n_aes_start   <= n_aes_start + 1;
        if (overrun)     n_overrun     <= n_overrun + 1;
        if (frame_err)   n_frame_err   <= n_frame_err + 1;
        if (frame_done)  n_frame_done  <= n_frame_done + 1;
        if (b_frame_err) n_b_frame_err <= n_b_frame_err + 1;
    end

    typedef struct {
        logic [127:0] data;     // bytes in send order, first byte in [127:120]
        logic [127:0] ct;
        bit           early;    // aes_ready already high during aes_start
        int           gap;      // idle cycles between bytes, -1 = random 0..3
        bit           ovr;      // inject 5A while waiting for cipher / transmitter
        int           prefix;   // partial bytes dropped by timeout before the frame
        int           abort_at; // byte index whose WAIT_TX gets a reset, -1 = none
        logic [127:0] exp_pt;
    } vec_t;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic inject_overrun();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        step();
        rx_valid = 1'b0;
        chk("overrun_pulse", overrun, 1);
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int t_tx, t_aes, t_ovr, t_fe, t_fd, ovr_cnt, g;
        logic [7:0] b, eb;
        bit early_err;
        t_tx = n_tx_start; t_aes = n_aes_start; t_ovr = n_overrun;
        t_fe = n_frame_err; t_fd = n_frame_done;
        ovr_cnt = 0;

        if (v.prefix > 0) begin
            for (int i = 0; i < v.prefix; i++) send_byte(8'(8'h11 * (i + 1)));
            early_err = 1'b0;
            for (int n = 1; n <= TMO_A; n++) begin
                if (n < TMO_A && frame_err) early_err = 1'b1;
                if (n < TMO_A) step();
                else step();
            end
            chk("frame_err_not_early", early_err, 0);
            chk("frame_err_at_timeout", frame_err, 1);
            chk("busy_after_timeout", busy, 0);
        end

        for (int i = 0; i < 16; i++) begin
            b = 8'(v.data >> (8 * (15 - i)));
            send_byte(b);
            if (i < 15) begin
                chk("aes_start_not_early", aes_start, 0);
                g = (v.gap < 0) ? int'($urandom_range(0, 3)) : v.gap;
                repeat (g) step();
            end
        end
        chk("aes_start", aes_start, 1);
        chk("pt_block", pt_to_aes, v.exp_pt);
        chk("busy_in_start", busy, 1);

        // a ready left high during aes_start must not be used: offer a stale block
        aes_ready   = v.early;
        ct_from_aes = ~v.ct;
        step();
        chk("aes_start_one_cycle", aes_start, 0);
        chk("no_tx_before_capture", tx_start, 0);
        ct_from_aes = v.ct;
        if (!v.early) begin
            repeat ($urandom_range(0, 4)) step();
            if (v.ovr) begin
                inject_overrun();
                ovr_cnt++;
            end
            aes_ready = 1'b1;
        end
        step();
        aes_ready   = 1'b0;
        ct_from_aes = {$urandom(), $urandom(), $urandom(), $urandom()};

        for (int k = 0; k < 16; k++) begin
            eb = 8'(v.ct >> (8 * (15 - k)));
            if (k == 0) begin
                chk("tx_start_first", tx_start, 1);
                chk("tx_data_first", tx_data, eb);
            end
            step();
            chk("tx_start_one_cycle", tx_start, 0);
            repeat ($urandom_range(0, 3)) step();
            if (v.ovr && k == 3) begin
                inject_overrun();
                ovr_cnt++;
            end
            if (k == v.abort_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk("reset_outputs_zero",
                    {tx_start, aes_start, busy, overrun, frame_err, frame_done, tx_data, pt_to_aes}, 0);
                t_tx = n_tx_start;
                for (int j = 0; j < 20; j++) begin
                    tx_done = (j % 4 == 0);
                    step();
                end
                tx_done = 1'b0;
                chk("no_tx_after_reset", n_tx_start - t_tx, 0);
                chk("idle_after_reset", busy, 0);
                $display("frame %0d: reset during byte %0d, frame abandoned", idx, k);
                return;
            end
            chk("tx_data_stable", tx_data, eb);
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            if (k < 15) begin
                chk("tx_start_after_done", tx_start, 1);
                chk("tx_data", tx_data, 8'(v.ct >> (8 * (14 - k))));
            end else begin
                chk("frame_done", frame_done, 1);
                chk("no_tx_after_last", tx_start, 0);
            end
        end
        step();
        chk("frame_done_one_cycle", frame_done, 0);
        chk("busy_low_after_frame", busy, 0);
        chk("pt_held", pt_to_aes, v.exp_pt);
        chk("tx_start_count", n_tx_start - t_tx, 16);
        chk("aes_start_count", n_aes_start - t_aes, 1);
        chk("frame_done_count", n_frame_done - t_fd, 1);
        chk("overrun_count", n_overrun - t_ovr, ovr_cnt);
        chk("frame_err_count", n_frame_err - t_fe, (v.prefix > 0) ? 1 : 0);
        $display("frame %0d: pt=%032h ct=%032h early=%0d prefix=%0d overruns=%0d",
                 idx, pt_to_aes, v.ct, v.early, v.prefix, ovr_cnt);
    endtask

    task automatic run_b();
        logic [31:0] exp_pt, ct;
        exp_pt = '0;
        ct     = 32'hA1B2C3D4;
        for (int i = 0; i < 4; i++) begin
            b_rx_valid = 1'b1;
            b_rx_data  = 8'(i + 1);
            step();
            b_rx_valid = 1'b0;
            exp_pt = exp_pt | (32'(i + 1) << (8 * i));
            if (i == 1) repeat (150) step();
            if (i < 3) chk("b_aes_start_not_early", b_aes_start, 0);
        end
        chk("b_aes_start", b_aes_start, 1);
        chk("b_pt_block", b_pt, exp_pt);
        b_aes_ready = 1'b1;
        b_ct        = ct;
        step();
        step();
        b_aes_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("b_tx_start", b_tx_start, 1);
            chk("b_tx_data", b_tx_data, 8'(ct >> (8 * k)));
            step();
            b_tx_done = 1'b1;
            step();
            b_tx_done = 1'b0;
        end
        chk("b_frame_done", b_frame_done, 1);
        chk("b_no_timeout", n_b_frame_err, 0);
        step();
        chk("b_busy_low", b_busy, 0);
        $display("frame B: pt=%08h ct=%08h", b_pt, ct);
    endtask

    task automatic run_c();
        c_rx_valid = 1'b1;
        c_rx_data  = 8'h7E;
        step();
        c_rx_valid = 1'b0;
        chk("c_aes_start", c_aes_start, 1);
        chk("c_pt", c_pt, 8'h7E);
        c_aes_ready = 1'b1;
        c_ct        = 8'hC3;
        step();
        step();
        c_aes_ready = 1'b0;
        chk("c_tx_start", c_tx_start, 1);
        chk("c_tx_data", c_tx_data, 8'hC3);
        step();
        c_tx_done = 1'b1;
        step();
        c_tx_done = 1'b0;
        chk("c_frame_done", c_frame_done, 1);
        step();
        chk("c_busy_low", c_busy, 0);
        $display("frame C: pt=%02h ct=%02h", c_pt, c_ct);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time %0t, required finish before limit", $time);
        $fatal(1, "bench stalled");
    end

    initial begin
        vec_t vecs[5];
        vec_t r;
        logic [127:0] e;
        logic [7:0] b;

        reset = 1'b1;
        rx_valid = 1'b0; rx_data = '0; tx_done = 1'b0; aes_ready = 1'b0; ct_from_aes = '0;
        b_rx_valid = 1'b0; b_rx_data = '0; b_tx_done = 1'b0; b_aes_ready = 1'b0; b_ct = '0;
        c_rx_valid = 1'b0; c_rx_data = '0; c_tx_done = 1'b0; c_aes_ready = 1'b0; c_ct = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_state_a",
            {tx_start, aes_start, busy, overrun, frame_err, frame_done, tx_data, pt_to_aes}, 0);
        chk("reset_state_b", {b_tx_start, b_aes_start, b_busy, b_tx_data, b_pt}, 0);
        step();

        vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, {4{32'hDEADBEEF}},
                    1'b1, -1, 1'b0, 0, -1, 128'h00112233445566778899AABBCCDDEEFF};
        vecs[1] = '{{16{8'hAA}}, 128'h0123456789ABCDEF0F1E2D3C4B5A6978,
                    1'b0, -1, 1'b1, 3, -1, {16{8'hAA}}};
        vecs[2] = '{128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 128'h13579BDF2468ACE0FEDCBA9876543210,
                    1'b0, 49, 1'b1, 0, -1, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F};
        vecs[3] = '{128'h0F0E0D0C0B0A09080706050403020100, 128'hCAFEBABE0BADF00D8BADF00DFEEDFACE,
                    1'b1, -1, 1'b0, 0, 7, 128'h0F0E0D0C0B0A09080706050403020100};
        vecs[4] = '{128'h112233445566778899AABBCCDDEEFF00, 128'h00FFEEDDCCBBAA998877665544332211,
                    1'b0, -1, 1'b0, 0, -1, 128'h112233445566778899AABBCCDDEEFF00};

        for (int i = 0; i < 5; i++) run_frame(i, vecs[i]);

        for (int i = 0; i < 6; i++) begin
            r.data     = {$urandom(), $urandom(), $urandom(), $urandom()};
            r.ct       = {$urandom(), $urandom(), $urandom(), $urandom()};
            r.early    = 1'($urandom_range(0, 1));
            r.gap      = -1;
            r.ovr      = 1'($urandom_range(0, 1));
            r.prefix   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
            r.abort_at = -1;
            // first byte sent lands in the top lane
            e = '0;
            for (int j = 0; j < 16; j++) begin
                b = 8'(r.data >> (8 * (15 - j)));
                e = {e[119:0], b};
            end
            r.exp_pt = e;
            run_frame(5 + i, r);
        end

        run_b();
        run_c();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_block_framer.md
Name: uart_block_framer

Overview:
- Parametrised byte-to-block framer between the UART byte layer (sample_ticker/UART_rx/UART_tx) and a block cipher core.
- Assembles NBYTES received bytes into one plaintext block, starts the cipher and waits for completion, then serialises the ciphertext back out byte by byte.
- Generalises the fixed 16-byte comm path with:
  - configurable block size and byte order;
  - an inter-byte timeout that resynchronises partial frames;
  - overrun and frame-error reporting.

Parameters:
- NBYTES, 16, bytes per block; block width is 8*NBYTES.
- TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of a partial frame; 0 disables the timeout.
- MSB_FIRST, 1, 1: first received/sent byte is block bits [8*NBYTES-1 -: 8]; 0: first byte is bits [7:0].

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse, rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_start  out  1  one-cycle pulse to UART_tx to send tx_data.
- tx_data  out  8  byte to transmit; stable from tx_start until tx_done.
- tx_done  in  1  one-cycle pulse from UART_tx, byte finished.
- aes_start  out  1  one-cycle pulse, pt_to_aes valid.
- aes_ready  in  1  level, cipher result valid on ct_from_aes.
- pt_to_aes  out  8*NBYTES  assembled plaintext block.
- ct_from_aes  in  8*NBYTES  ciphertext block.
- busy  out  1  high whenever state is not RECV.
- overrun  out  1  one-cycle pulse, byte dropped.
- frame_err  out  1  one-cycle pulse, partial frame discarded by timeout.
- frame_done  out  1  one-cycle pulse, last ciphertext byte sent.

Behaviour:
- Reset, synchronous and dominant over every other input:
  - state=RECV;
  - byte counter=0, timeout counter=0;
  - pt_to_aes=0, tx_data=0;
  - tx_start, aes_start, busy, overrun, frame_err, frame_done all 0;
  - internal ciphertext register=0.
- Reset mid-operation abandons the frame, with no further tx_start or aes_start.
- States: RECV, START, WAIT_AES, SEND, WAIT_TX, DONE.
- RECV:
  - On rx_valid, the byte is written into pt_to_aes at slot cnt (slot order per MSB_FIRST), cnt increments, timeout counter clears.
  - If cnt==NBYTES-1 on accept: cnt becomes 0 and the next state is START.
  - pt_to_aes bytes outside the written slots keep their previous values.
- Timeout (RECV only, when cnt>0 and TIMEOUT_CYCLES>0):
  - The counter increments every cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 and no rx_valid is present: cnt=0, counter=0, frame_err pulses next cycle.
  - If rx_valid coincides with expiry, the byte is accepted and no error is raised.
- START: aes_start=1 for exactly one cycle; go to WAIT_AES. aes_start therefore rises 1 cycle after the final rx_valid.
- WAIT_AES:
  - aes_ready is ignored in the cycle aes_start is high. A stale ready must not be used.
  - From the next cycle, the first cycle with aes_ready=1 captures ct_from_aes into the internal register; go to SEND.
  - There is no timeout; the block waits indefinitely.
- SEND:
  - tx_data is driven with ciphertext byte k (k counts 0..NBYTES-1, order per MSB_FIRST).
  - tx_start=1 for one cycle, then go to WAIT_TX.
  - Byte 0 tx_start occurs 1 cycle after capture.
- WAIT_TX:
  - On tx_done, if k<NBYTES-1: k increments and the next state is SEND. The next tx_start therefore follows tx_done by 1 cycle.
  - On tx_done with k==NBYTES-1: go to DONE.
  - tx_done seen in any other state is ignored.
- DONE: frame_done=1 for one cycle; k=0; return to RECV.
- Overrun:
  - An rx_valid while busy=1 discards the byte; overrun pulses the following cycle.
  - pt_to_aes and cnt are unchanged.
- Stability:
  - pt_to_aes is stable from aes_start until the next frame's first accepted byte.
  - tx_data is stable from tx_start until tx_done.
- NBYTES=1 is legal: a single byte completes the frame.
- Counter widths: byte counters are clog2(NBYTES) bits, minimum 1. The timeout counter is clog2(TIMEOUT_CYCLES+1) bits.

Test Plan:
- NBYTES=16, MSB_FIRST=1: send bytes 00,11,…,FF -> aes_start pulses 1 cycle after 16th rx_valid; pt_to_aes=00112233445566778899AABBCCDDEEFF.
- Hold aes_ready=1 before and through aes_start, ct=DEADBEEF×4 -> capture no earlier than cycle after aes_start; 16 tx_start pulses with tx_data DE,AD,BE,EF… each 1 cycle after preceding tx_done; frame_done after 16th tx_done; busy low afterwards.
- MSB_FIRST=0, NBYTES=4: send 01,02,03,04 -> pt_to_aes=32'h04030201; ct=32'hA1B2C3D4 transmitted D4,C3,B2,A1.
- TIMEOUT_CYCLES=50: send 3 bytes, idle 50 cycles -> frame_err single pulse, cnt=0; next 16 bytes AA..AA form a clean block of all AA.
- rx_valid with byte 5A during WAIT_AES and WAIT_TX -> overrun pulse each time, pt_to_aes unchanged, transmitted ciphertext unaffected.
- Assert reset for 1 cycle during WAIT_TX at byte 7 -> all outputs 0 next cycle, no further tx_start; a subsequent full 16-byte frame processes normally.
